// File: rtl/serial_fa_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_fa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must reach WIDTH-1 and stay representable for any legal WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder: the carry cell plus the sum cell, wired as a single bit slice.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and carry cells.
  assign p   = a ^ b;
  assign sum = p ^ ci;
  assign co  = (a & b) | (ci & p);

endmodule

// File: rtl/serial_fa_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first, one bit per clock,
// with valid/ready handshakes on request and result.
module serial_fa_ctrl
  import serial_fa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             fa_sum, fa_co;

  fa_bit u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .ci  (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      co_q     <= co_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    co_d     = co_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands drain LSB first; each new sum bit enters at the top.
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_sum;
        carry_d             = fa_co;
        cnt_d               = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sum_sh_d;
          co_d    = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept is blocked for the whole cycle a reset is being applied.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign co        = co_q;

endmodule
